// File: rtl/dtp_pkg.sv
// Shared types for the decision-tree walker: FSM state encoding, node word
// layout helpers and a node_t builder for the default field widths.
package dtp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ATTR,
      S_FETCH,
      S_DECODE,
      S_EMIT,
      S_SWITCH,
      S_DONE
   } state_t;

   localparam int ATTR_WIDTH_D = 16;
   localparam int ATTR_ABIT_D  = 5;
   localparam int NODE_ABIT_D  = 8;

   // Node word is {leaf, attr_idx, threshold, left_addr}, left_addr at bit 0.
   function automatic int node_width(input int attr_abit, input int attr_width, input int node_abit);
      return 1 + attr_abit + attr_width + node_abit;
   endfunction

   function automatic int thr_lsb(input int node_abit);
      return node_abit;
   endfunction

   function automatic int attr_lsb(input int node_abit, input int attr_width);
      return node_abit + attr_width;
   endfunction

   typedef struct packed {
      logic                   leaf;
      logic [ATTR_ABIT_D-1:0]  attr_idx;
      logic [ATTR_WIDTH_D-1:0] threshold;
      logic [NODE_ABIT_D-1:0]  left_addr;
   } node_t;

   function automatic node_t make_node(input logic                    leaf,
                                       input logic [ATTR_ABIT_D-1:0]  attr_idx,
                                       input logic [ATTR_WIDTH_D-1:0] threshold,
                                       input logic [NODE_ABIT_D-1:0]  left_addr);
      node_t n;
      n.leaf      = leaf;
      n.attr_idx  = attr_idx;
      n.threshold = threshold;
      n.left_addr = left_addr;
      return n;
   endfunction

endpackage

// File: rtl/dtp_node_decode.sv
// Combinational node unpack: field split, unsigned attribute compare and
// child address selection (right child is left_addr+1, wrapping).
module dtp_node_decode
   import dtp_pkg::*;
#(
   parameter int ATTR_WIDTH  = 16,
   parameter int ATTR_ABIT   = 5,
   parameter int NODE_ABIT   = 8,
   parameter int CLASS_WIDTH = 4
) (
   input  logic [ATTR_ABIT+ATTR_WIDTH+NODE_ABIT:0] node,
   input  logic [ATTR_WIDTH-1:0]                   attr_val,
   output logic                                    leaf,
   output logic [ATTR_ABIT-1:0]                    attr_idx,
   output logic [CLASS_WIDTH-1:0]                  leaf_class,
   output logic [NODE_ABIT-1:0]                    next_addr
);

   localparam int NODE_W   = node_width(ATTR_ABIT, ATTR_WIDTH, NODE_ABIT);
   localparam int THR_LSB  = thr_lsb(NODE_ABIT);
   localparam int ATTR_LSB = attr_lsb(NODE_ABIT, ATTR_WIDTH);

   logic [ATTR_WIDTH-1:0] threshold;
   logic [NODE_ABIT-1:0]  left_addr;

   assign leaf       = node[NODE_W-1];
   assign attr_idx   = node[ATTR_LSB +: ATTR_ABIT];
   assign threshold  = node[THR_LSB +: ATTR_WIDTH];
   assign left_addr  = node[0 +: NODE_ABIT];
   assign leaf_class = threshold[CLASS_WIDTH-1:0];
   assign next_addr  = (attr_val <= threshold) ? left_addr : left_addr + NODE_ABIT'(1);

endmodule

// File: rtl/dtp_tree_walker.sv
// Decision-tree walker: classifies one sample per attribute RAM by walking
// node memory from a root. Optional statistics counters: DTP_WALKER_STATS_EN.
module dtp_tree_walker
   import dtp_pkg::*;
#(
   parameter int ATTR_WIDTH  = 16,
   parameter int ATTR_ABIT   = 5,
   parameter int NODE_ABIT   = 8,
   parameter int CLASS_WIDTH = 4,
   parameter int MAX_DEPTH   = 16
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    i_start,
   input  logic [NODE_ABIT-1:0]                    i_root_addr,
   output logic                                    o_node_rd,
   output logic [NODE_ABIT-1:0]                    o_node_addr,
   input  logic [ATTR_ABIT+ATTR_WIDTH+NODE_ABIT:0] i_node_data,
   input  logic                                    i_is_att_ram_avai,
   input  logic                                    i_is_sample_done,
   output logic [ATTR_ABIT-1:0]                    o_attr_ram_sel,
   input  logic [ATTR_WIDTH-1:0]                   i_attr_ram_dout,
   output logic                                    o_att_ram_switch,
   output logic                                    o_res_vld,
   input  logic                                    i_res_rdy,
   output logic [CLASS_WIDTH-1:0]                  o_res_class,
   output logic                                    o_busy,
   output logic                                    o_done,
   output logic                                    o_depth_err,
   output state_t                                  o_state
`ifdef DTP_WALKER_STATS_EN
   ,
   output logic [15:0]                             o_sample_cnt,
   output logic [31:0]                             o_node_cnt
`endif
);

   // Result handshake: a class transfers on a cycle with o_res_vld & i_res_rdy;
   // o_res_class is held stable while o_res_vld waits for i_res_rdy.

   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   state_t                 state_q, state_n;
   logic [NODE_ABIT-1:0]   root_q, root_n;
   logic [NODE_ABIT-1:0]   addr_q, addr_n;
   logic [DEPTH_W-1:0]     depth_q, depth_n;
   logic [CLASS_WIDTH-1:0] class_q, class_n;
   logic [ATTR_ABIT-1:0]   sel_q, sel_n;
   logic                   depth_err;

   logic                   dec_leaf;
   logic [ATTR_ABIT-1:0]   dec_attr_idx;
   logic [CLASS_WIDTH-1:0] dec_class;
   logic [NODE_ABIT-1:0]   dec_next_addr;

   dtp_node_decode #(
      .ATTR_WIDTH (ATTR_WIDTH),
      .ATTR_ABIT  (ATTR_ABIT),
      .NODE_ABIT  (NODE_ABIT),
      .CLASS_WIDTH(CLASS_WIDTH)
   ) u_decode (
      .node      (i_node_data),
      .attr_val  (i_attr_ram_dout),
      .leaf      (dec_leaf),
      .attr_idx  (dec_attr_idx),
      .leaf_class(dec_class),
      .next_addr (dec_next_addr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         root_q  <= '0;
         addr_q  <= '0;
         depth_q <= '0;
         class_q <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_n;
         root_q  <= root_n;
         addr_q  <= addr_n;
         depth_q <= depth_n;
         class_q <= class_n;
         sel_q   <= sel_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      root_n    = root_q;
      addr_n    = addr_q;
      depth_n   = depth_q;
      class_n   = class_q;
      sel_n     = sel_q;
      depth_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               root_n  = i_root_addr;
               state_n = S_WAIT_ATTR;
            end
         end
         S_WAIT_ATTR: begin
            if (i_is_att_ram_avai) begin
               addr_n  = root_q;
               depth_n = '0;
               state_n = S_FETCH;
            end else if (i_is_sample_done) begin
               state_n = S_DONE;
            end
         end
         S_FETCH: state_n = S_DECODE;
         S_DECODE: begin
            if (dec_leaf) begin
               class_n = dec_class;
               state_n = S_EMIT;
            end else begin
               sel_n = dec_attr_idx;
               // The visit budget is spent: report with the reserved all-ones class.
               if (depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
                  depth_err = 1'b1;
                  class_n   = '1;
                  state_n   = S_EMIT;
               end else begin
                  addr_n  = dec_next_addr;
                  depth_n = depth_q + DEPTH_W'(1);
                  state_n = S_FETCH;
               end
            end
         end
         S_EMIT:   if (i_res_rdy) state_n = S_SWITCH;
         S_SWITCH: state_n = S_WAIT_ATTR;
         S_DONE:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // The attribute select must be live during DECODE for the same-cycle compare.
   assign o_attr_ram_sel   = (state_q == S_DECODE && !dec_leaf) ? dec_attr_idx : sel_q;
   assign o_node_rd        = (state_q == S_FETCH);
   assign o_node_addr      = addr_q;
   assign o_att_ram_switch = (state_q == S_SWITCH);
   assign o_res_vld        = (state_q == S_EMIT);
   assign o_res_class      = class_q;
   assign o_busy           = (state_q != S_IDLE);
   assign o_done           = (state_q == S_DONE);
   assign o_depth_err      = depth_err;
   assign o_state          = state_q;

`ifdef DTP_WALKER_STATS_EN
   logic [15:0] sample_cnt_q;
   logic [31:0] node_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt_q <= '0;
         node_cnt_q   <= '0;
      end else begin
         if (state_q == S_EMIT && i_res_rdy && sample_cnt_q != '1)
            sample_cnt_q <= sample_cnt_q + 16'd1;
         if (state_q == S_DECODE && node_cnt_q != '1)
            node_cnt_q <= node_cnt_q + 32'd1;
      end
   end

   assign o_sample_cnt = sample_cnt_q;
   assign o_node_cnt   = node_cnt_q;
`endif

endmodule

// File: tb/tb_dtp_tree_walker.sv
// Directed bench for dtp_tree_walker: node/attribute memory models, a read
// address and class scoreboard checked by a negedge monitor, and a summary.
module tb_dtp_tree_walker;
   import dtp_pkg::*;

   localparam int AW = 16, AA = 5, NA = 8, CW = 4, MD = 16;
   localparam int NW = 1 + AA + AW + NA;

   logic          clk, rst_n, start, node_rd, avai, sample_done;
   logic          att_switch, res_vld, res_rdy, busy, done, depth_err;
   logic [NA-1:0] root_addr, node_addr;
   logic [NW-1:0] node_data;
   logic [AA-1:0] attr_sel;
   logic [AW-1:0] attr_dout;
   logic [CW-1:0] res_class;
   state_t        state;
`ifdef DTP_WALKER_STATS_EN
   logic [15:0]   sample_cnt;
   logic [31:0]   node_cnt;
`endif

   logic [NW-1:0] node_mem [256];
   logic [AW-1:0] attr_mem [32];

   int            n_cmp, n_fail, sw_cnt, done_cnt, err_cnt;
   logic [NA-1:0] addr_q [$];
   logic [CW-1:0] exp_q [$];

   dtp_tree_walker #(
      .ATTR_WIDTH(AW), .ATTR_ABIT(AA), .NODE_ABIT(NA), .CLASS_WIDTH(CW), .MAX_DEPTH(MD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_start          (start),
      .i_root_addr      (root_addr),
      .o_node_rd        (node_rd),
      .o_node_addr      (node_addr),
      .i_node_data      (node_data),
      .i_is_att_ram_avai(avai),
      .i_is_sample_done (sample_done),
      .o_attr_ram_sel   (attr_sel),
      .i_attr_ram_dout  (attr_dout),
      .o_att_ram_switch (att_switch),
      .o_res_vld        (res_vld),
      .i_res_rdy        (res_rdy),
      .o_res_class      (res_class),
      .o_busy           (busy),
      .o_done           (done),
      .o_depth_err      (depth_err),
      .o_state          (state)
`ifdef DTP_WALKER_STATS_EN
      ,
      .o_sample_cnt     (sample_cnt),
      .o_node_cnt       (node_cnt)
`endif
   );

   // Clock / reset and memory models
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (node_rd) node_data <= node_mem[node_addr];
   assign attr_dout = attr_mem[attr_sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a read or a result
   always @(negedge clk) begin
      if (node_rd) begin
         if (addr_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL node_read: got unexpected read of %0d, expected none", node_addr);
         end else check("node_addr", 32'(node_addr), 32'(addr_q.pop_front()));
      end
      if (res_vld && res_rdy) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL result: got unexpected class %0h, expected none", res_class);
         end else check("res_class", 32'(res_class), 32'(exp_q.pop_front()));
      end
      if (att_switch) sw_cnt++;
      if (done)       done_cnt++;
      if (depth_err)  err_cnt++;
   end

   // Driver tasks
   task automatic start_stream(input logic [NA-1:0] root);
      @(posedge clk); #1;
      root_addr = root;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic wait_result(input string name, input int exp_lat, input int hold);
      int            cnt = 0;
      bit            ok  = 1'b0;
      logic [CW-1:0] held;
      int            sw0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cnt++;
         if (res_vld) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: got no o_res_vld, expected one within 300 cycles", name);
         return;
      end
      if (exp_lat >= 0) check({name, "_latency"}, cnt, exp_lat);
      if (hold > 0) begin
         held = res_class;
         sw0  = sw_cnt;
         for (int k = 0; k < hold; k++) begin
            check({name, "_hold_vld"}, 32'(res_vld), 32'd1);
            check({name, "_hold_class"}, 32'(res_class), 32'(held));
            if (k < hold - 1) @(negedge clk);
         end
         check({name, "_no_switch_before_accept"}, sw_cnt, sw0);
         @(posedge clk); #1;
         res_rdy = 1'b1;
         @(negedge clk);
      end
      // handshake is visible now; it is taken at the next rising edge
      @(posedge clk); #1;
      avai = 1'b0;
      @(negedge clk);
      check({name, "_switch_pulse"}, 32'(att_switch), 32'd1);
      @(negedge clk);
      check({name, "_switch_single"}, 32'(att_switch), 32'd0);
   endtask

   task automatic finish_stream(input string name);
      bit ok = 1'b0;
      int d0 = done_cnt;
      @(posedge clk); #1;
      sample_done = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      check({name, "_done_seen"}, 32'(ok), 32'd1);
      @(negedge clk);
      check({name, "_done_count"}, done_cnt - d0, 1);
      check({name, "_idle_after_done"}, 32'(state), 32'(S_IDLE));
      check({name, "_not_busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      sample_done = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, s0;
      n_cmp = 0; n_fail = 0; sw_cnt = 0; done_cnt = 0; err_cnt = 0;
      rst_n = 1'b0; start = 1'b0; root_addr = '0; avai = 1'b0;
      sample_done = 1'b0; res_rdy = 1'b1; node_data = '0;
      for (int i = 0; i < 256; i++) node_mem[i] = '0;
      for (int i = 0; i < 32; i++) attr_mem[i] = '0;
      node_mem[10] = make_node(1'b1, 5'd0, 16'h0005, 8'd0);
      node_mem[20] = make_node(1'b0, 5'd3, 16'd100, 8'd4);
      node_mem[4]  = make_node(1'b1, 5'd0, 16'h0007, 8'd0);
      node_mem[5]  = make_node(1'b1, 5'd0, 16'h0009, 8'd0);
      node_mem[30] = make_node(1'b0, 5'd1, 16'h8000, 8'd255);
      node_mem[0]  = make_node(1'b1, 5'd0, 16'h0003, 8'd0);
      node_mem[40] = make_node(1'b0, 5'd2, 16'hFFFF, 8'd40);
      attr_mem[1] = 16'hFFFF;
      attr_mem[2] = 16'h1234;
      attr_mem[3] = 16'd100;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", 32'(state), 32'(S_IDLE));
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_vld", 32'(res_vld), 32'd0);
      check("reset_node_rd", 32'(node_rd), 32'd0);
      check("reset_node_addr", 32'(node_addr), 32'd0);
      check("reset_attr_sel", 32'(attr_sel), 32'd0);
      check("reset_class", 32'(res_class), 32'd0);

      // Single leaf root
      avai = 1'b1;
      addr_q.push_back(8'd10); exp_q.push_back(4'h5);
      start_stream(8'd10);
      wait_result("leaf_root", 4, 0);
      finish_stream("leaf_root");

      // Depth-2 tree: equal goes left, greater goes right, two samples one stream
      avai = 1'b1;
      addr_q.push_back(8'd20); addr_q.push_back(8'd4); exp_q.push_back(4'h7);
      start_stream(8'd20);
      wait_result("cmp_equal", 6, 0);
      @(posedge clk); #1;
      attr_mem[3] = 16'd101;
      addr_q.push_back(8'd20); addr_q.push_back(8'd5); exp_q.push_back(4'h9);
      avai = 1'b1;
      wait_result("cmp_greater", -1, 0);
      finish_stream("cmp");
      check("attr_sel_holds", 32'(attr_sel), 32'd3);

      // Right child of left_addr=255 wraps to node 0; compare is unsigned
      avai = 1'b1;
      addr_q.push_back(8'd30); addr_q.push_back(8'd0); exp_q.push_back(4'h3);
      start_stream(8'd30);
      wait_result("wrap", 6, 0);
      finish_stream("wrap");

      // Self-looping node exhausts the depth budget
      e0 = err_cnt;
      avai = 1'b1;
      for (int i = 0; i < MD; i++) addr_q.push_back(8'd40);
      exp_q.push_back(4'hF);
      start_stream(8'd40);
      wait_result("depth", 2 + 2 * MD, 0);
      check("depth_err_pulses", err_cnt - e0, 1);
      finish_stream("depth");

      // Backpressure, with avai and sample_done both high at the start
      avai = 1'b1; sample_done = 1'b1; res_rdy = 1'b0;
      addr_q.push_back(8'd10); exp_q.push_back(4'h5);
      start_stream(8'd10);
      wait_result("backpressure", 4, 5);
      finish_stream("backpressure");

      // Reset while in FETCH abandons the sample without a switch pulse
      avai = 1'b1;
      addr_q.push_back(8'd10);
      start_stream(8'd10);
      begin
         bit ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (node_rd) begin ok = 1'b1; break; end
         end
         check("reset_fetch_reached", 32'(ok), 32'd1);
      end
      rst_n = 1'b0;
      s0 = sw_cnt;
      @(posedge clk); #1;
      check("midreset_state", 32'(state), 32'(S_IDLE));
      check("midreset_node_addr", 32'(node_addr), 32'd0);
      check("midreset_attr_sel", 32'(attr_sel), 32'd0);
      check("midreset_vld", 32'(res_vld), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; avai = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midreset_no_switch", sw_cnt, s0);
      check("midreset_idle", 32'(busy), 32'd0);

      check("addr_q_drained", addr_q.size(), 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dtp_tree_walker.md
DTP_TREE_WALKER -- requirements
Module: dtp_tree_walker

Interface
REQ-001 Parameter ATTR_WIDTH, default 16, attribute and threshold width.
REQ-002 Parameter ATTR_ABIT, default 5, attribute index width.
REQ-003 Parameter NODE_ABIT, default 8, node memory address width.
REQ-004 Parameter CLASS_WIDTH, default 4, class label width, at most ATTR_WIDTH.
REQ-005 Parameter MAX_DEPTH, default 16, maximum node visits per sample.
REQ-006 Node word NODE_W = 1+ATTR_ABIT+ATTR_WIDTH+NODE_ABIT, packed MSB to LSB as {leaf, attr_idx, threshold, left_addr}.
REQ-007 One clock; reset is synchronous and active-low.
REQ-008 Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_start  in  1  begin a sample stream.
- i_root_addr  in  NODE_ABIT  root node address, sampled on start.
- o_node_rd  out  1  node memory read strobe.
- o_node_addr  out  NODE_ABIT  node memory address.
- i_node_data  in  NODE_W  node word, valid exactly 1 cycle after o_node_rd.
- i_is_att_ram_avai  in  1  attribute RAM holds a sample for this walker.
- i_is_sample_done  in  1  FIFO and both attribute RAMs are empty.
- o_attr_ram_sel  out  ATTR_ABIT  attribute index.
- i_attr_ram_dout  in  ATTR_WIDTH  attribute value, combinational from o_attr_ram_sel.
- o_att_ram_switch  out  1  one-cycle release of the current attribute RAM.
- o_res_vld / i_res_rdy / o_res_class  out/in/out  1/1/CLASS_WIDTH  result handshake.
- o_busy  out  1  walker is not in IDLE.
- o_done  out  1  one-cycle end-of-stream pulse.
- o_depth_err  out  1  one-cycle pulse on depth overflow.

Function
REQ-009 The FSM SHALL have the states IDLE, WAIT_ATTR, FETCH, DECODE, EMIT, SWITCH and DONE.
REQ-010 IDLE SHALL move to WAIT_ATTR on i_start, latching i_root_addr.
REQ-011 WAIT_ATTR SHALL behave as follows:
- i_is_att_ram_avai=1: go to FETCH, load the root address, clear the depth counter.
- else i_is_sample_done=1: go to DONE.
- avai SHALL take priority when both are asserted.
REQ-012 FETCH SHALL assert o_node_rd for 1 cycle with o_node_addr equal to the current address, then go to DECODE.
REQ-013 DECODE with leaf=1 SHALL latch class = threshold[CLASS_WIDTH-1:0] and go to EMIT.
REQ-014 DECODE with leaf=0 SHALL compare in the same cycle:
- drive o_attr_ram_sel = attr_idx.
- next address = left_addr if unsigned i_attr_ram_dout <= threshold, else left_addr+1, wrapping mod 2^NODE_ABIT.
- increment the depth counter and go to FETCH.
REQ-015 Depth limit: when a non-leaf DECODE occurs with depth counter == MAX_DEPTH-1, the walker SHALL:
- pulse o_depth_err.
- set class to all-ones.
- go to EMIT.
REQ-016 EMIT SHALL hold o_res_vld=1 with o_res_class stable until i_res_rdy=1, then go to SWITCH.
REQ-017 SWITCH SHALL assert o_att_ram_switch (Moore output) for exactly 1 cycle, then go to WAIT_ATTR.
- Avai is sampled no earlier than 1 cycle after the switch pulse.
REQ-018 DONE SHALL pulse o_done for 1 cycle, then go to IDLE.
REQ-019 o_attr_ram_sel SHALL hold its last value outside DECODE.
REQ-020 Latency SHALL be 2 cycles per visited node, plus 1 cycle for EMIT when i_res_rdy=1, plus 1 cycle for SWITCH.
REQ-021 i_start outside IDLE SHALL be ignored.

Reset
REQ-022 On rst_n=0 at a clock edge, at any time including mid-walk:
- state = IDLE.
- All outputs and the address, depth and class registers = 0.
- No switch pulse SHALL be issued for an abandoned sample.

Configuration
REQ-023 With DTP_WALKER_STATS_EN defined, the following outputs SHALL exist:
- o_sample_cnt (16 bits): increments on each result accepted (o_res_vld & i_res_rdy).
- o_node_cnt (32 bits): increments on each DECODE.
- Both SHALL saturate, reset to 0 and hold through DONE.
REQ-024 Without DTP_WALKER_STATS_EN, these ports and their registers SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-025 Package dtp_pkg SHALL hold:
- the FSM state enum.
- the node field widths and offsets.
- the packed node_t struct builder.
REQ-026 Sub-module dtp_node_decode SHALL perform the combinational unpack, compare and next-address computation.

Verification
REQ-027 Single-node tree (root leaf, threshold=0x0005), avai=1, rdy=1 -> o_res_class=5; switch pulse exactly 1 cycle after the handshake.
REQ-028 Depth-2 tree, root attr_idx=3, threshold=100, left_addr=4, with attr[3]=100 -> reads node 4; with attr[3]=101 -> reads node 5.
REQ-029 Self-looping non-leaf node, MAX_DEPTH=16 -> o_depth_err after 16 DECODEs, o_res_class=0xF.
REQ-030 i_res_rdy held 0 for 5 cycles -> o_res_vld and class stable for 5 cycles, no switch until accept.
REQ-031 avai=0, sample_done=1 in WAIT_ATTR -> o_done pulse, IDLE next cycle; reset asserted during FETCH -> IDLE and no switch pulse.
